line_beat_serializer: RTL and testbench

LINE_BEAT_SERIALIZER -- requirements
Module: line_beat_serializer

---
 rtl/line_beat_serializer_if.sv | 28 ++
 rtl/line_beat_serializer.sv | 66 ++++++
 tb/tb_line_beat_serializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_beat_serializer_if.sv
// line_beat_serializer_if: line-buffer and beat-bus signals of the serializer
//   line       upstream line at the buffer tail, valid while line_empty=0
//   line_empty upstream buffer empty flag
//   line_pop   one-cycle pop strobe to the upstream buffer
//   beat       current output beat, beat_valid/beat_last qualify it
//   beat_ready downstream accepts the beat
//   busy       a line is held in the serializer
interface line_beat_serializer_if #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32
);
    logic [LINE_W-1:0] line;
    logic              line_empty;
    logic              line_pop;
    logic [BEAT_W-1:0] beat;
    logic              beat_valid;
    logic              beat_last;
    logic              beat_ready;
    logic              busy;
    modport master (
        input  line, line_empty, beat_ready,
        output line_pop, beat, beat_valid, beat_last, busy
    );
    modport slave (
        output line, line_empty, beat_ready,
        input  line_pop, beat, beat_valid, beat_last, busy
    );
endinterface

// File: rtl/line_beat_serializer.sv
// line_beat_serializer: pops lines from an upstream buffer and emits them as BEATS beats, lowest slice first
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    line_beat_serializer_if.master (line side in, beat side out, busy)
module line_beat_serializer #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32
) (
    input logic clk,
    input logic reset,
    line_beat_serializer_if.master bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW = $clog2(BEATS);

    generate
        if (LINE_W <= BEAT_W || LINE_W % BEAT_W != 0 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_params
            $error("line_beat_serializer: LINE_W must be a power-of-2 multiple (>1) of BEAT_W");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [LINE_W-1:0] line_r;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     nxt;
    logic              hs;
    logic              last_hs;
    logic              load;

    assign nxt     = cnt + CW'(1);
    assign hs      = state == SEND && bus.beat_ready;
    assign last_hs = hs && cnt == CW'(BEATS - 1);
    // A pop happens either from IDLE or on the last-beat handshake, giving back-to-back lines
    assign load     = !reset && !bus.line_empty && (state == IDLE || last_hs);
    assign bus.line_pop = load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.beat_valid <= 1'b0;
            bus.beat_last  <= 1'b0;
            bus.busy       <= 1'b0;
        end else if (load) begin
            state          <= SEND;
            line_r         <= bus.line;
            cnt            <= '0;
            bus.beat       <= bus.line[BEAT_W-1:0];
            bus.beat_valid <= 1'b1;
            bus.beat_last  <= 1'b0;
            bus.busy       <= 1'b1;
        end else if (last_hs) begin
            state          <= IDLE;
            bus.beat_valid <= 1'b0;
            bus.beat_last  <= 1'b0;
            bus.busy       <= 1'b0;
        end else if (hs) begin
            // Outputs are registered, so preload the slice for the next count
            cnt           <= nxt;
            bus.beat      <= line_r[nxt*BEAT_W +: BEAT_W];
            bus.beat_last <= nxt == CW'(BEATS - 1);
        end
    end
endmodule

// File: tb/tb_line_beat_serializer.sv
// tb_line_beat_serializer: scoreboard bench for line_beat_serializer
module tb_line_beat_serializer;
    localparam int LINE_W = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS = LINE_W / BEAT_W;

    typedef struct {
        logic [BEAT_W-1:0] beat;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    line_beat_serializer_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();
    line_beat_serializer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pops = 0;
    int lasts = 0;
    int up_rd = 0;
    logic [LINE_W-1:0] up_q[$];
    exp_t exp_q[$];
    int hs_log[$];
    int pop_log[$];
    bit hold_empty = 1'b0;
    bit rand_empty = 1'b0;
    int ready_mode = 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Upstream buffer and downstream sink model: drive on the falling edge
    initial begin
        bit gap;
        bus.line = '0;
        bus.line_empty = 1'b1;
        bus.beat_ready = 1'b0;
        forever begin
            @(negedge clk);
            gap = rand_empty && ($urandom_range(0, 9) < 3);
            bus.line_empty = hold_empty || gap || up_q.size() <= up_rd;
            bus.line = up_q.size() > up_rd ? up_q[up_rd] : '0;
            bus.beat_ready = ready_mode == 2 ? ($urandom_range(0, 9) < 7) : (ready_mode == 1);
        end
    end

    // Monitor: samples 2 time units before each rising edge
    initial begin
        logic [LINE_W-1:0] l;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (reset) begin
                check("pop_in_reset", bus.line_pop, 0);
                exp_q.delete();
            end else begin
                check("valid", bus.beat_valid, exp_q.size() != 0);
                check("busy", bus.busy, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    check("beat", bus.beat, exp_q[0].beat);
                    check("last", bus.beat_last, exp_q[0].last);
                end else begin
                    check("last_idle", bus.beat_last, 0);
                end
                if (bus.beat_valid && bus.beat_ready) begin
                    if (bus.beat_last) lasts++;
                    if (exp_q.size() != 0) exp_q.pop_front();
                    hs_log.push_back(cyc);
                end
                if (bus.line_pop) begin
                    check("pop_not_empty", bus.line_empty, 0);
                    if (up_q.size() > up_rd) begin
                        l = up_q[up_rd];
                        for (int i = 0; i < BEATS; i++) exp_q.push_back('{l[i*BEAT_W +: BEAT_W], i == BEATS - 1});
                        up_rd++;
                    end
                    pops++;
                    pop_log.push_back(cyc);
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(up_rd == up_q.size() && exp_q.size() == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: not drained after %0d cycles, pending beats %0d required 0", name, n, exp_q.size());
        end
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_log.size() < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: %0d handshakes after %0d cycles, required %0d", name, hs_log.size(), n, target);
        end
    endtask

    initial begin
        int h0;
        int p0;
        int l0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #3;
        check("rst_valid", bus.beat_valid, 0);
        check("rst_last", bus.beat_last, 0);
        check("rst_busy", bus.busy, 0);

        // Single line
        @(posedge clk);
        #1;
        h0 = hs_log.size();
        p0 = pop_log.size();
        up_q.push_back(128'h44444444_33333333_22222222_11111111);
        wait_drain("single_drain", 50);
        check("single_pops", pop_log.size() - p0, 1);
        check("single_beats", hs_log.size() - h0, 4);
        check("single_latency", hs_log[h0] - pop_log[p0], 1);
        check("single_span", hs_log[h0+3] - hs_log[h0], 3);
        @(posedge clk);
        #1;
        check("single_idle", bus.busy, 0);

        // Back-to-back lines
        h0 = hs_log.size();
        p0 = pop_log.size();
        up_q.push_back(128'h44444444_33333333_22222222_11111111);
        up_q.push_back(128'h88888888_77777777_66666666_55555555);
        wait_drain("b2b_drain", 50);
        check("b2b_pops", pop_log.size() - p0, 2);
        check("b2b_beats", hs_log.size() - h0, 8);
        check("b2b_span", hs_log[h0+7] - hs_log[h0], 7);
        check("b2b_pop_on_last", pop_log[p0+1], hs_log[h0+3]);

        // Backpressure on beat 2
        h0 = hs_log.size();
        up_q.push_back(128'h44444444_33333333_22222222_11111111);
        wait_hs("bp_reach", h0 + 2, 50);
        ready_mode = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            check("bp_hold_beat", bus.beat, 32'h33333333);
            check("bp_hold_valid", bus.beat_valid, 1);
        end
        ready_mode = 1;
        wait_drain("bp_drain", 50);
        check("bp_stall", hs_log[h0+2] - hs_log[h0+1], 4);
        check("bp_beats", hs_log.size() - h0, 4);

        // Empty hold-off
        @(posedge clk);
        #1;
        p0 = pop_log.size();
        hold_empty = 1'b1;
        up_q.push_back(128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #3;
            check("hold_pop", bus.line_pop, 0);
            check("hold_valid", bus.beat_valid, 0);
            check("hold_busy", bus.busy, 0);
        end
        hold_empty = 1'b0;
        wait_drain("hold_drain", 50);
        check("hold_pops", pop_log.size() - p0, 1);

        // Reset after beat 1 accepted
        @(posedge clk);
        #1;
        h0 = hs_log.size();
        p0 = pop_log.size();
        up_q.push_back(128'h44444444_33333333_22222222_11111111);
        wait_hs("rm_reach", h0 + 2, 50);
        hold_empty = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #3;
        check("rm_valid", bus.beat_valid, 0);
        check("rm_busy", bus.busy, 0);
        check("rm_pop", bus.line_pop, 0);
        check("rm_pops", pop_log.size() - p0, 1);
        @(posedge clk);
        #1;
        hold_empty = 1'b0;
        h0 = hs_log.size();
        up_q.push_back(128'h0000000d_0000000c_0000000b_0000000a);
        wait_drain("rm_drain", 50);
        check("rm_new_beats", hs_log.size() - h0, 4);

        // Random traffic
        p0 = pops;
        l0 = lasts;
        rand_empty = 1'b1;
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) up_q.push_back({$urandom, $urandom, $urandom, $urandom});
        wait_drain("rand_drain", 40000);
        check("rand_pops", pops - p0, 1000);
        check("rand_lasts", lasts - l0, pops - p0);
        rand_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
